// File: rtl/fc_seq_ctrl_if.sv
// Port bundle for fc_seq_ctrl: activation stream in, weight memory read, result stream out.
// master is the controller side; slave is the surrounding datapath (previous layer, weight RAM, next stage).
interface fc_seq_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int IN    = 128,
   parameter int OUT   = 10
);
   localparam int ACC_W = WIDTH * 2 + $clog2(IN);
   localparam int AW    = $clog2(OUT * (IN + 1));
   localparam int IW    = (OUT > 1) ? $clog2(OUT) : 1;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             w_en;
   logic [AW-1:0]    w_addr;
   logic [WIDTH-1:0] w_data;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic [IW-1:0]    out_idx;
   logic             busy;

   modport master (
      input  in_valid, in_data, w_data, out_ready,
      output in_ready, w_en, w_addr, out_valid, out_data, out_idx, busy
   );

   modport slave (
      output in_valid, in_data, w_data, out_ready,
      input  in_ready, w_en, w_addr, out_valid, out_data, out_idx, busy
   );
endinterface

// File: rtl/fc_seq_ctrl.sv
// Time-multiplexed FC+ReLU controller on one shared MAC; FC_BIAS_EN adds a per-neuron bias word (k=IN).
// Result NW+1 cycles after CALC entry; out_ready low stalls in OUT with weight reads halted; input taken only in LOAD.
module fc_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int IN    = 128,
   parameter int OUT   = 10
) (
   input logic           clk,
   input logic           rst_n,
   fc_seq_ctrl_if.master bus
);
   localparam int ACC_W = WIDTH * 2 + $clog2(IN);
   localparam int AW    = $clog2(OUT * (IN + 1));
   localparam int IW    = (OUT > 1) ? $clog2(OUT) : 1;
`ifdef FC_BIAS_EN
   localparam int NW    = IN + 1;
`else
   localparam int NW    = IN;
`endif
   localparam int KW    = (NW > 1) ? $clog2(NW) : 1;
   localparam int BW    = (IN > 1) ? $clog2(IN) : 1;

   typedef enum logic [1:0] {S_LOAD, S_CALC, S_DRAIN, S_OUT} state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [KW-1:0]           r_k;
   logic [KW-1:0]           r_rd_k;
   logic                    r_rd_vld;
   logic [IW-1:0]           r_n;
   logic [AW-1:0]           r_base;
   logic signed [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0]        r_out_data;
   logic [IW-1:0]           r_out_idx;
   logic [WIDTH-1:0]        r_buf [IN];

   logic                    w_in_hs;
   logic                    w_load_last;
   logic                    w_calc_last;
   logic                    w_n_last;
   logic [WIDTH-1:0]        w_act;
   logic signed [2*WIDTH-1:0] w_prod;
   logic signed [ACC_W-1:0] w_term;
   logic signed [ACC_W-1:0] w_sum;

   assign w_in_hs     = bus.in_valid && (r_state == S_LOAD);
   assign w_load_last = (r_k == KW'(IN - 1));
   assign w_calc_last = (r_k == KW'(NW - 1));
   assign w_n_last    = (r_n == IW'(OUT - 1));

   // w_data answers the read issued last cycle, so the MAC pairs it with r_rd_k, not r_k.
   assign w_act  = r_buf[r_rd_k[BW-1:0]];
   assign w_prod = {{WIDTH{w_act[WIDTH-1]}}, w_act} * {{WIDTH{bus.w_data[WIDTH-1]}}, bus.w_data};

   always_comb begin
      w_term = '0;
      if (r_rd_vld) w_term = ACC_W'(w_prod);
`ifdef FC_BIAS_EN
      if (r_rd_vld && (r_rd_k == KW'(IN))) w_term = ACC_W'($signed(bus.w_data));
`endif
   end

   assign w_sum = r_acc + w_term;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_LOAD;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_LOAD:  if (w_in_hs && w_load_last) w_next = S_CALC;
         S_CALC:  if (w_calc_last) w_next = S_DRAIN;
         S_DRAIN: w_next = S_OUT;
         S_OUT:   if (bus.out_ready) w_next = w_n_last ? S_LOAD : S_CALC;
         default: w_next = S_LOAD;
      endcase
   end

   always_comb begin
      bus.in_ready  = (r_state == S_LOAD);
      bus.w_en      = (r_state == S_CALC);
      bus.w_addr    = (r_state == S_CALC) ? (r_base + AW'(r_k)) : '0;
      bus.out_valid = (r_state == S_OUT);
      bus.busy      = (r_state != S_LOAD);
   end

   assign bus.out_data = r_out_data;
   assign bus.out_idx  = r_out_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k        <= '0;
         r_rd_k     <= '0;
         r_rd_vld   <= 1'b0;
         r_n        <= '0;
         r_base     <= '0;
         r_acc      <= '0;
         r_out_data <= '0;
         r_out_idx  <= '0;
      end else begin
         r_rd_vld <= (r_state == S_CALC);
         r_rd_k   <= r_k;
         case (r_state)
            S_LOAD: begin
               r_acc <= '0;
               if (w_in_hs) r_k <= w_load_last ? '0 : r_k + KW'(1);
            end
            S_CALC: begin
               r_k   <= w_calc_last ? '0 : r_k + KW'(1);
               r_acc <= w_sum;
            end
            S_DRAIN: begin
               r_acc      <= w_sum;
               r_out_data <= w_sum[ACC_W-1] ? '0 : w_sum;
               r_out_idx  <= r_n;
            end
            S_OUT: begin
               if (bus.out_ready) begin
                  r_acc <= '0;
                  r_k   <= '0;
                  if (w_n_last) begin
                     r_n    <= '0;
                     r_base <= '0;
                  end else begin
                     r_n    <= r_n + IW'(1);
                     r_base <= r_base + AW'(NW);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Activation buffer is deliberately left out of reset; every entry is rewritten before use.
   always_ff @(posedge clk) begin
      if (w_in_hs) r_buf[r_k[BW-1:0]] <= bus.in_data;
   end
endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Randomized scoreboard bench for fc_seq_ctrl (IN=4, OUT=3) with a dot-product reference model.
module tb_fc_seq_ctrl;
   localparam int W   = 8;
   localparam int IN  = 4;
   localparam int OUT = 3;
`ifdef FC_BIAS_EN
   localparam int NW  = IN + 1;
`else
   localparam int NW  = IN;
`endif
   localparam int ACC_W = 2 * W + $clog2(IN);
   localparam int IW    = (OUT > 1) ? $clog2(OUT) : 1;

   typedef struct {
      longint data;
      int     idx;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   fc_seq_ctrl_if #(.WIDTH(W), .IN(IN), .OUT(OUT)) bus ();
   fc_seq_ctrl #(.WIDTH(W), .IN(IN), .OUT(OUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   res_t exp_q[$];
   int   addr_q[$];
   int   wmem [OUT*NW];
   int   acts [IN];
   int   rdy_mode = 0;
   int   stall_cnt = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.w_en) bus.w_data <= W'(wmem[int'(bus.w_addr)]);
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_w_en", bus.w_en, 0);
      chk("rst_w_addr", bus.w_addr, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_idx", bus.out_idx, 0);
      chk("rst_busy", bus.busy, 0);
   endtask

   // Reference: per neuron dot product (+ bias word when present), ReLU, and the address sweep it needs.
   function automatic void push_expect();
      int s;
      for (int n = 0; n < OUT; n++) begin
         s = 0;
         for (int k = 0; k < IN; k++) s += acts[k] * wmem[n*NW + k];
         if (NW > IN) s += wmem[n*NW + IN];
         exp_q.push_back('{data: longint'((s < 0) ? 0 : s), idx: n});
         for (int k = 0; k < NW; k++) addr_q.push_back(n*NW + k);
      end
   endfunction

   function automatic int rnd8();
      return int'($urandom_range(255)) - 128;
   endfunction

   task automatic send_vector(input int gaps[IN], input int junk);
      push_expect();
      for (int k = 0; k < IN; k++) begin
         bus.in_valid = 1'b0;
         repeat (gaps[k]) begin @(posedge clk); #1; end
         bus.in_valid = 1'b1;
         bus.in_data  = W'(acts[k]);
         for (int t = 0; !bus.in_ready; t++) begin
            if (t == 500) begin chk("in_ready_timeout", 0, 1); break; end
            @(posedge clk); #1;
         end
         @(posedge clk); #1;
      end
      // Offered while busy; must be ignored.
      bus.in_valid = (junk > 0);
      bus.in_data  = W'($urandom);
      repeat (junk) begin @(posedge clk); #1; bus.in_data = W'($urandom); end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 3000; t++) begin
         if (exp_q.size() == 0 && !bus.busy) return;
         @(posedge clk); #1;
      end
      chk("idle_timeout", 0, 1);
   endtask

   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            1: bus.out_ready = 1'b1;
            2: begin
               if (bus.out_valid && stall_cnt < 5) begin
                  bus.out_ready = 1'b0;
                  stall_cnt++;
               end else begin
                  bus.out_ready = 1'b1;
                  if (!bus.out_valid) stall_cnt = 0;
               end
            end
            default: bus.out_ready = ($urandom_range(3) != 0);
         endcase
      end
   end

   int               in_cnt = 0;
   bit               exp_wen = 0, last_done = 0, hold_v = 0, prev_ov = 0;
   logic [ACC_W-1:0] held_data;
   logic [IW-1:0]    held_idx;
   int               t0 = 0;
   int               a;
   res_t             r;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_cnt = 0; exp_wen = 0; last_done = 0; hold_v = 0; prev_ov = 0;
      end else begin
         if (exp_wen) begin chk("calc_starts_next_cycle", bus.w_en, 1); exp_wen = 0; end
         if (last_done) begin chk("idle_after_last", {bus.in_ready, bus.busy}, 2'b10); last_done = 0; end
         if (bus.w_en) begin
            if (addr_q.size() == 0) chk("w_addr_unexpected", bus.w_addr, -1);
            else begin
               a = addr_q.pop_front();
               chk("w_addr", bus.w_addr, a);
               if (a % NW == 0) t0 = cyc;
            end
         end
         if (bus.out_valid && !prev_ov) chk("calc_to_valid_latency", cyc - t0, NW + 1);
         if (bus.out_valid) chk("w_en_low_in_out", bus.w_en, 0);
         if (hold_v) chk("stall_hold", {bus.out_valid, bus.out_data, bus.out_idx}, {1'b1, held_data, held_idx});
         hold_v    = bus.out_valid && !bus.out_ready;
         held_data = bus.out_data;
         held_idx  = bus.out_idx;
         prev_ov   = bus.out_valid;
         if (bus.in_valid && bus.in_ready) begin
            in_cnt++;
            if (in_cnt == IN) begin in_cnt = 0; exp_wen = 1; end
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", bus.out_idx, -1);
            else begin
               r = exp_q.pop_front();
               chk("out_data", bus.out_data, r.data);
               chk("out_idx", bus.out_idx, r.idx);
               if (r.idx == OUT - 1) last_done = 1;
               else exp_wen = 1;
            end
         end
      end
   end

   initial begin
      int gaps [IN];
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs();
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Positive/negative unit weights on 1,2,3,4.
      gaps = '{0, 0, 0, 0};
      acts = '{1, 2, 3, 4};
      for (int i = 0; i < OUT*NW; i++) wmem[i] = 0;
      for (int k = 0; k < IN; k++) begin
         wmem[k] = 1;
         wmem[NW + k] = -1;
         wmem[2*NW + k] = rnd8();
      end
      rdy_mode = 0;
      send_vector(gaps, 2);
      wait_idle();

      // Worst-case magnitude: everything at -128.
      acts = '{-128, -128, -128, -128};
      for (int i = 0; i < OUT*NW; i++) wmem[i] = -128;
      rdy_mode = 1;
      send_vector(gaps, 0);
      wait_idle();

      // Five-cycle stall on every result.
      for (int k = 0; k < IN; k++) acts[k] = rnd8();
      for (int i = 0; i < OUT*NW; i++) wmem[i] = rnd8();
      rdy_mode = 2;
      send_vector(gaps, 3);
      wait_idle();

      // Gapped input pattern 1,0,0,1,1,0,1.
      gaps = '{0, 2, 0, 1};
      for (int k = 0; k < IN; k++) acts[k] = rnd8();
      for (int i = 0; i < OUT*NW; i++) wmem[i] = rnd8();
      rdy_mode = 0;
      send_vector(gaps, 1);
      wait_idle();

`ifdef FC_BIAS_EN
      gaps = '{0, 0, 0, 0};
      acts = '{1, 2, 3, 4};
      for (int k = 0; k < IN; k++) begin
         wmem[k] = 1;
         wmem[NW + k] = -1;
         wmem[2*NW + k] = rnd8();
      end
      wmem[IN] = 5;
      wmem[NW + IN] = 5;
      wmem[2*NW + IN] = -128;
      send_vector(gaps, 0);
      wait_idle();
`endif

      for (int v = 0; v < 8; v++) begin
         for (int k = 0; k < IN; k++) begin
            acts[k] = rnd8();
            gaps[k] = int'($urandom_range(2));
         end
         for (int i = 0; i < OUT*NW; i++) wmem[i] = rnd8();
         send_vector(gaps, int'($urandom_range(3)));
         wait_idle();
      end

      // Reset in the middle of neuron 1's CALC.
      gaps = '{0, 0, 0, 0};
      for (int k = 0; k < IN; k++) acts[k] = rnd8();
      for (int i = 0; i < OUT*NW; i++) wmem[i] = rnd8();
      send_vector(gaps, 0);
      for (int t = 0; !(bus.w_en && bus.w_addr == NW + 1); t++) begin
         if (t == 500) begin chk("reach_neuron1_timeout", 0, 1); break; end
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      exp_q.delete();
      addr_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < IN; k++) acts[k] = rnd8();
      for (int i = 0; i < OUT*NW; i++) wmem[i] = rnd8();
      send_vector(gaps, 1);
      wait_idle();

      chk("results_drained", exp_q.size(), 0);
      chk("addresses_drained", addr_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
